// File: rtl/pipeline_ctrl_pkg.sv
// ============================================================================
// Module   : pipeline_ctrl_pkg
// Brief    : Shared types and constants for the pipeline hazard controller:
//            the controller state enumeration and the PC source selects.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipeline_ctrl_pkg;

   // Controller states: post-reset blanking, normal run, redirect flush,
   // interrupt entry and the one-cycle bubble after a predicted-taken fetch.
   typedef enum logic [2:0] {
      ST_RST   = 3'd0,
      ST_RUN   = 3'd1,
      ST_FLUSH = 3'd2,
      ST_INT   = 3'd3,
      ST_PRED  = 3'd4
   } hz_state_t;

   // PC source selects
   localparam logic [2:0] PC_SEQ       = 3'd0;
   localparam logic [2:0] PC_INT       = 3'd2;
   localparam logic [2:0] PC_REDIR_DEF = 3'd3;
   localparam logic [2:0] PC_PRED      = 3'd4;

endpackage

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_match.sv
// ============================================================================
// Module   : hazard_match
// Brief    : Compares one decode source register against every producer
//            stage destination and reports a per-stage hit vector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_match #(
   parameter int REG_AW = 5,
   parameter int NSTG   = 2
) (
   input  logic [REG_AW-1:0]      src,
   input  logic                   src_rd,
   input  logic [NSTG*REG_AW-1:0] dst_addr,
   input  logic [NSTG-1:0]        dst_en,
   output logic [NSTG-1:0]        hit
);

   // A hit needs the operand to be read and the stage to actually write it
   genvar i;
   generate
      for (i = 0; i < NSTG; i++) begin : g_stage
         assign hit[i] = src_rd && dst_en[i] &&
                         (src == dst_addr[i*REG_AW +: REG_AW]);
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Brief    : Pipeline hazard and PC-sequencing controller. Detects RAW
//            hazards, stalls or forwards, sequences redirects, predicted-taken
//            fetches, interrupt entry and post-reset blanking, and counts
//            RAW stall cycles.
// Options  : define HAZARD_FWD_EN to add operand forwarding; only a load in
//            stage 0 then causes a stall, and fwd_a_sel/fwd_b_sel appear.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl #(
   parameter int REG_AW    = 5,
   parameter int NSTG      = 2,
   parameter int FLUSH_CYC = 2,
   parameter int INT_CYC   = 3,
   parameter int RST_CYC   = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [REG_AW-1:0]      src_a,
   input  logic [REG_AW-1:0]      src_b,
   input  logic                   src_a_rd,
   input  logic                   src_b_rd,
   input  logic [NSTG*REG_AW-1:0] dst_addr,
   input  logic [NSTG-1:0]        dst_en,
   input  logic                   ex_is_load,
   input  logic                   redirect_req,
   input  logic [2:0]             redirect_src,
   input  logic                   predict_taken,
   input  logic                   irq,
   input  logic                   irq_en,
   output logic                   pc_reset,
   output logic                   pc_load,
   output logic                   pc_inc,
   output logic                   pc_stall,
   output logic                   fetch_stall,
   output logic                   dec_nop,
   output logic                   dec_int,
   output logic [2:0]             pc_mux_sel,
   output logic [15:0]            stall_cycles
`ifdef HAZARD_FWD_EN
   ,
   output logic [$clog2(NSTG+1)-1:0] fwd_a_sel,
   output logic [$clog2(NSTG+1)-1:0] fwd_b_sel
`endif
);

   import pipeline_ctrl_pkg::*;

   // Counter reload values: cnt counts remaining blank cycles minus one
   localparam logic [2:0] c_rst_cnt   = 3'(RST_CYC - 1);
   localparam logic [2:0] c_flush_cnt = 3'(FLUSH_CYC - 1);
   localparam logic [2:0] c_int_cnt   = 3'(INT_CYC - 1);

   logic [NSTG-1:0] w_hit_a;
   logic [NSTG-1:0] w_hit_b;
   logic            w_raw_stall;
   logic            w_irq_take;

   hz_state_t   r_state;
   hz_state_t   w_state_nxt;
   logic [2:0]  r_cnt;
   logic [2:0]  w_cnt_nxt;
   logic [15:0] r_stall_cycles;

   hazard_match #(.REG_AW(REG_AW), .NSTG(NSTG)) u_match_a (
      .src      (src_a),
      .src_rd   (src_a_rd),
      .dst_addr (dst_addr),
      .dst_en   (dst_en),
      .hit      (w_hit_a)
   );

   hazard_match #(.REG_AW(REG_AW), .NSTG(NSTG)) u_match_b (
      .src      (src_b),
      .src_rd   (src_b_rd),
      .dst_addr (dst_addr),
      .dst_en   (dst_en),
      .hit      (w_hit_b)
   );

`ifdef HAZARD_FWD_EN
   localparam int FW = $clog2(NSTG+1);

   // Only a load in EX cannot be forwarded in time; everything else bypasses
   assign w_raw_stall = (w_hit_a[0] || w_hit_b[0]) && ex_is_load;

   // Forward from the youngest (lowest-index) matching producer
   always_comb begin
      fwd_a_sel = '0;
      fwd_b_sel = '0;
      if (!reset) begin
         for (int i = NSTG-1; i >= 0; i--) begin
            if (w_hit_a[i]) fwd_a_sel = FW'(i + 1);
            if (w_hit_b[i]) fwd_b_sel = FW'(i + 1);
         end
      end
   end
`else
   logic w_unused_load;
   assign w_unused_load = ex_is_load;

   // No bypass network: any match must stall
   assign w_raw_stall = (|w_hit_a) || (|w_hit_b);
`endif

   assign w_irq_take = irq && irq_en;
   assign pc_reset   = reset;

   // State register: reset forces post-reset blanking regardless of state
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_RST;
         r_cnt   <= c_rst_cnt;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next-state logic with RUN event priority irq > redirect > stall > predict
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_RUN: begin
            if (w_irq_take) begin
               w_state_nxt = ST_INT;
               w_cnt_nxt   = c_int_cnt;
            end else if (redirect_req) begin
               w_state_nxt = ST_FLUSH;
               w_cnt_nxt   = c_flush_cnt;
            end else if (w_raw_stall) begin
               w_state_nxt = ST_RUN;
            end else if (predict_taken) begin
               w_state_nxt = ST_PRED;
            end
         end
         ST_FLUSH: begin
            if (redirect_req) begin
               w_cnt_nxt = c_flush_cnt;
            end else if (r_cnt == 3'd0) begin
               w_state_nxt = ST_RUN;
            end else begin
               w_cnt_nxt = r_cnt - 3'd1;
            end
         end
         ST_PRED: begin
            if (redirect_req) begin
               w_state_nxt = ST_FLUSH;
               w_cnt_nxt   = c_flush_cnt;
            end else begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_INT, ST_RST: begin
            if (r_cnt == 3'd0) begin
               w_state_nxt = ST_RUN;
            end else begin
               w_cnt_nxt = r_cnt - 3'd1;
            end
         end
         default: begin
            w_state_nxt = ST_RST;
            w_cnt_nxt   = c_rst_cnt;
         end
      endcase
   end

   // Output decode; reset overrides every state and event
   always_comb begin
      pc_load     = 1'b0;
      pc_stall    = 1'b0;
      fetch_stall = 1'b0;
      dec_nop     = 1'b0;
      dec_int     = 1'b0;
      pc_mux_sel  = PC_SEQ;
      if (reset) begin
         dec_nop = 1'b1;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (w_irq_take) begin
                  dec_int = 1'b1;
                  dec_nop = 1'b1;
               end else if (redirect_req) begin
                  pc_load    = 1'b1;
                  pc_mux_sel = redirect_src;
                  dec_nop    = 1'b1;
               end else if (w_raw_stall) begin
                  pc_stall    = 1'b1;
                  fetch_stall = 1'b1;
                  dec_nop     = 1'b1;
               end else if (predict_taken) begin
                  pc_load     = 1'b1;
                  pc_mux_sel  = PC_PRED;
                  fetch_stall = 1'b1;
               end
            end
            ST_FLUSH, ST_PRED: begin
               dec_nop = 1'b1;
               if (redirect_req) begin
                  pc_load    = 1'b1;
                  pc_mux_sel = redirect_src;
               end
            end
            ST_INT: begin
               dec_nop = 1'b1;
               // cnt only counts down, so the reload value marks the first cycle
               if (r_cnt == c_int_cnt) begin
                  pc_load    = 1'b1;
                  pc_mux_sel = PC_INT;
               end
            end
            default: begin
               dec_nop = 1'b1;
            end
         endcase
      end
      pc_inc = !reset && !pc_load && !pc_stall;
   end

   // Saturating count of cycles in which a RAW hazard requests a stall
   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall_cycles <= 16'd0;
      end else if (w_raw_stall && (r_stall_cycles != 16'hFFFF)) begin
         r_stall_cycles <= r_stall_cycles + 16'd1;
      end
   end

   assign stall_cycles = r_stall_cycles;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Brief    : Self-checking bench for pipeline_hazard_ctrl: directed scenarios
//            with literal expectations followed by randomized traffic checked
//            every cycle against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_ctrl;

   localparam int REG_AW    = 5;
   localparam int NSTG      = 2;
   localparam int FLUSH_CYC = 2;
   localparam int INT_CYC   = 3;
   localparam int RST_CYC   = 2;
   localparam int FW        = $clog2(NSTG+1);

   logic                   clk = 1'b0;
   logic                   reset;
   logic [REG_AW-1:0]      src_a, src_b;
   logic                   src_a_rd, src_b_rd;
   logic [NSTG*REG_AW-1:0] dst_addr;
   logic [NSTG-1:0]        dst_en;
   logic                   ex_is_load, redirect_req, predict_taken, irq, irq_en;
   logic [2:0]             redirect_src;
   logic                   pc_reset, pc_load, pc_inc, pc_stall, fetch_stall;
   logic                   dec_nop, dec_int;
   logic [2:0]             pc_mux_sel;
   logic [15:0]            stall_cycles;
`ifdef HAZARD_FWD_EN
   logic [FW-1:0]          fwd_a_sel, fwd_b_sel;
`endif

   int n_checks = 0;
   int n_errors = 0;

   pipeline_hazard_ctrl #(
      .REG_AW(REG_AW), .NSTG(NSTG), .FLUSH_CYC(FLUSH_CYC),
      .INT_CYC(INT_CYC), .RST_CYC(RST_CYC)
   ) dut (
      .clk(clk), .reset(reset),
      .src_a(src_a), .src_b(src_b), .src_a_rd(src_a_rd), .src_b_rd(src_b_rd),
      .dst_addr(dst_addr), .dst_en(dst_en), .ex_is_load(ex_is_load),
      .redirect_req(redirect_req), .redirect_src(redirect_src),
      .predict_taken(predict_taken), .irq(irq), .irq_en(irq_en),
      .pc_reset(pc_reset), .pc_load(pc_load), .pc_inc(pc_inc),
      .pc_stall(pc_stall), .fetch_stall(fetch_stall), .dec_nop(dec_nop),
      .dec_int(dec_int), .pc_mux_sel(pc_mux_sel), .stall_cycles(stall_cycles)
`ifdef HAZARD_FWD_EN
      , .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic at_mid();
      @(negedge clk);
   endtask

   // ---------------------------------------------------------------------
   // Behavioural model. Phases: 0 running, 1 post-reset blank, 2 flush,
   // 3 interrupt entry, 4 predicted-taken bubble. m_left counts the blank
   // cycles still owed, m_age counts cycles since interrupt entry.
   // ---------------------------------------------------------------------
   int m_phase  = 1;
   int m_left   = RST_CYC;
   int m_age    = 0;
   int m_stalls = 0;

   always @(negedge clk) begin : model
      int  d, fa, fb;
      bit  ha, hb, any_hit, hit0, raw;
      int  e_load, e_sel, e_stall, e_fst, e_nop, e_int, e_inc;
      fa = 0; fb = 0; any_hit = 0; hit0 = 0;
      for (int s = NSTG-1; s >= 0; s--) begin
         d  = (int'(dst_addr) >> (s*REG_AW)) % (1 << REG_AW);
         ha = src_a_rd && dst_en[s] && (int'(src_a) == d);
         hb = src_b_rd && dst_en[s] && (int'(src_b) == d);
         if (ha) fa = s + 1;
         if (hb) fb = s + 1;
         if (ha || hb) begin
            any_hit = 1;
            if (s == 0) hit0 = 1;
         end
      end
`ifdef HAZARD_FWD_EN
      raw = hit0 && ex_is_load;
`else
      raw = any_hit;
`endif
      e_load = 0; e_sel = 0; e_stall = 0; e_fst = 0; e_nop = 0; e_int = 0;
      if (reset) begin
         e_nop = 1;
         fa = 0; fb = 0;
      end else begin
         if (m_phase == 0) begin
            if (irq && irq_en) begin
               e_int = 1; e_nop = 1;
            end else if (redirect_req) begin
               e_load = 1; e_sel = int'(redirect_src); e_nop = 1;
            end else if (raw) begin
               e_stall = 1; e_fst = 1; e_nop = 1;
            end else if (predict_taken) begin
               e_load = 1; e_sel = 4; e_fst = 1;
            end
         end else begin
            e_nop = 1;
            if ((m_phase == 2 || m_phase == 4) && redirect_req) begin
               e_load = 1; e_sel = int'(redirect_src);
            end
            if (m_phase == 3 && m_age == 0) begin
               e_load = 1; e_sel = 2;
            end
         end
      end
      e_inc = (!reset && e_load == 0 && e_stall == 0) ? 1 : 0;

      chk("pc_reset",     int'(pc_reset),     int'(reset));
      chk("pc_load",      int'(pc_load),      e_load);
      chk("pc_mux_sel",   int'(pc_mux_sel),   e_sel);
      chk("pc_stall",     int'(pc_stall),     e_stall);
      chk("fetch_stall",  int'(fetch_stall),  e_fst);
      chk("dec_nop",      int'(dec_nop),      e_nop);
      chk("dec_int",      int'(dec_int),      e_int);
      chk("pc_inc",       int'(pc_inc),       e_inc);
      chk("stall_cycles", int'(stall_cycles), m_stalls);
`ifdef HAZARD_FWD_EN
      chk("fwd_a_sel",    int'(fwd_a_sel),    fa);
      chk("fwd_b_sel",    int'(fwd_b_sel),    fb);
`endif

      // Advance the model to the next cycle
      if (reset) begin
         m_phase = 1; m_left = RST_CYC; m_stalls = 0;
      end else begin
         if (raw && m_stalls < 65535) m_stalls++;
         case (m_phase)
            0: begin
               if (irq && irq_en) begin
                  m_phase = 3; m_left = INT_CYC; m_age = 0;
               end else if (redirect_req) begin
                  m_phase = 2; m_left = FLUSH_CYC;
               end else if (!raw && predict_taken) begin
                  m_phase = 4;
               end
            end
            2: begin
               if (redirect_req) m_left = FLUSH_CYC;
               else begin
                  m_left--;
                  if (m_left == 0) m_phase = 0;
               end
            end
            4: begin
               if (redirect_req) begin
                  m_phase = 2; m_left = FLUSH_CYC;
               end else m_phase = 0;
            end
            default: begin
               m_age++;
               m_left--;
               if (m_left == 0) m_phase = 0;
            end
         endcase
      end
   end

   task automatic clear_inputs();
      src_a = '0; src_b = '0; src_a_rd = 0; src_b_rd = 0;
      dst_addr = '0; dst_en = '0; ex_is_load = 0;
      redirect_req = 0; redirect_src = 3'd0; predict_taken = 0;
      irq = 0; irq_en = 0;
   endtask

   initial begin
      reset = 1'b1;
      clear_inputs();

      // Reset held three cycles, then released
      tick();
      at_mid();
      chk("lit_rst_pc_reset", int'(pc_reset), 1);
      chk("lit_rst_dec_nop",  int'(dec_nop),  1);
      chk("lit_rst_pc_inc",   int'(pc_inc),   0);
      tick(); tick();
      reset = 1'b0;
      at_mid();
      chk("lit_rel1_dec_nop", int'(dec_nop), 1);
      tick();
      at_mid();
      chk("lit_rel2_dec_nop", int'(dec_nop), 1);
      tick();
      at_mid();
      chk("lit_run_dec_nop", int'(dec_nop), 0);
      chk("lit_run_pc_inc",  int'(pc_inc),  1);

`ifdef HAZARD_FWD_EN
      // Stage-0 match on a non-load forwards instead of stalling
      tick();
      src_a = 5'd5; src_a_rd = 1; dst_addr = 10'd5; dst_en = 2'b01;
      at_mid();
      chk("lit_fwd0_pc_stall", int'(pc_stall),  0);
      chk("lit_fwd0_sel",      int'(fwd_a_sel), 1);
      tick();
      dst_addr = 10'd5 << 5; dst_en = 2'b10;
      at_mid();
      chk("lit_fwd1_pc_stall", int'(pc_stall),  0);
      chk("lit_fwd1_sel",      int'(fwd_a_sel), 2);
      tick();
      clear_inputs();
      at_mid();
      chk("lit_fwd_stall_cycles", int'(stall_cycles), 0);
`else
      // Stage-0 match held two cycles stalls for two cycles
      tick();
      src_a = 5'd5; src_a_rd = 1; dst_addr = 10'd5; dst_en = 2'b01;
      at_mid();
      chk("lit_raw1_pc_stall", int'(pc_stall), 1);
      chk("lit_raw1_dec_nop",  int'(dec_nop),  1);
      tick();
      at_mid();
      chk("lit_raw2_pc_stall", int'(pc_stall), 1);
      chk("lit_raw2_dec_nop",  int'(dec_nop),  1);
      tick();
      clear_inputs();
      at_mid();
      chk("lit_raw_stall_cycles", int'(stall_cycles), 2);
      chk("lit_raw_done_stall",   int'(pc_stall),     0);
`endif

      // Interrupt and redirect together: interrupt wins
      tick();
      redirect_req = 1; redirect_src = 3'd5; irq = 1; irq_en = 1;
      at_mid();
      chk("lit_irq_dec_int", int'(dec_int), 1);
      chk("lit_irq_dec_nop", int'(dec_nop), 1);
      chk("lit_irq_pc_load", int'(pc_load), 0);
      tick();
      clear_inputs();
      at_mid();
      chk("lit_int1_pc_load", int'(pc_load),    1);
      chk("lit_int1_sel",     int'(pc_mux_sel), 2);
      chk("lit_int1_dec_nop", int'(dec_nop),    1);
      tick();
      at_mid();
      chk("lit_int2_dec_nop", int'(dec_nop), 1);
      chk("lit_int2_pc_load", int'(pc_load), 0);
      tick();
      at_mid();
      chk("lit_int3_dec_nop", int'(dec_nop), 1);
      tick();
      at_mid();
      chk("lit_int_done_dec_nop", int'(dec_nop), 0);

      // Predict-taken during a RAW stall waits until the stall clears
      tick();
      src_a = 5'd5; src_a_rd = 1; dst_addr = 10'd5; dst_en = 2'b01;
      ex_is_load = 1; predict_taken = 1;
      at_mid();
      chk("lit_pst_pc_load",  int'(pc_load),  0);
      chk("lit_pst_pc_stall", int'(pc_stall), 1);
      tick();
      src_a_rd = 0; dst_en = 2'b00;
      at_mid();
      chk("lit_pred_pc_load", int'(pc_load),     1);
      chk("lit_pred_sel",     int'(pc_mux_sel),  4);
      chk("lit_pred_fstall",  int'(fetch_stall), 1);
      tick();
      at_mid();
      chk("lit_predb_dec_nop", int'(dec_nop), 1);
      chk("lit_predb_pc_load", int'(pc_load), 0);
      tick();
      clear_inputs();
      at_mid();
      chk("lit_pred_done_dec_nop", int'(dec_nop), 0);

      // Randomized traffic; small address range keeps hazards frequent
      for (int c = 0; c < 4000; c++) begin
         tick();
         reset         = ($urandom_range(0, 99) == 0);
         src_a         = REG_AW'($urandom_range(0, 3));
         src_b         = REG_AW'($urandom_range(0, 3));
         src_a_rd      = $urandom_range(0, 1) == 1;
         src_b_rd      = $urandom_range(0, 1) == 1;
         dst_addr      = {REG_AW'($urandom_range(0, 3)), REG_AW'($urandom_range(0, 3))};
         dst_en        = NSTG'($urandom_range(0, 3));
         ex_is_load    = $urandom_range(0, 1) == 1;
         redirect_req  = ($urandom_range(0, 7) == 0);
         redirect_src  = 3'($urandom_range(0, 7));
         predict_taken = ($urandom_range(0, 5) == 0);
         irq           = ($urandom_range(0, 11) == 0);
         irq_en        = $urandom_range(0, 1) == 1;
      end
      tick();
      clear_inputs();
      at_mid();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL provide parameter REG_AW, default 5, register address width.
REQ-002 SHALL provide parameter NSTG, default 2, number of producer stages checked; stage 0 is the one nearest decode (EX), range 1..4.
REQ-003 SHALL provide parameter FLUSH_CYC, default 2, decode-nop cycles after a redirect, range 1..7.
REQ-004 SHALL provide parameter INT_CYC, default 3, decode-nop cycles for interrupt entry, range 1..7.
REQ-005 SHALL provide parameter RST_CYC, default 2, decode-nop cycles after reset deasserts, range 1..7.
REQ-006 SHALL have ports (name direction width meaning):
- clk in 1 clock, rising edge.
- reset in 1 synchronous, active-high.
- src_a / src_b in REG_AW decode source register addresses.
- src_a_rd / src_b_rd in 1 source actually read.
- dst_addr in NSTG*REG_AW packed destinations; stage i is at bits [i*REG_AW +: REG_AW].
- dst_en in NSTG producer stage writes a register.
- ex_is_load in 1 stage-0 producer is a load.
- redirect_req in 1 branch miss, call or return resolved this cycle.
- redirect_src in 3 PC source for the redirect.
- predict_taken in 1 fetch predicts a taken branch.
- irq in 1 interrupt request.
- irq_en in 1 interrupt enable flag.
- pc_reset out 1 PC reset.
- pc_load out 1 PC load.
- pc_inc out 1 PC increment.
- pc_stall out 1 hold PC.
- fetch_stall out 1 hold fetch latch and instruction-memory address.
- dec_nop out 1 replace decode instruction with a nop.
- dec_int out 1 inject interrupt into decode.
- pc_mux_sel out 3 PC source select.
- stall_cycles out 16 RAW stall counter.
- fwd_a_sel / fwd_b_sel out $clog2(NSTG+1) forwarding select; present only with the macro.

Function
REQ-007 hit_x[i] SHALL be (src_x==dst_addr[i]) && src_x_rd && dst_en[i], evaluated combinationally for each of stages a and b.
REQ-008 raw_stall SHALL be the OR of every hit when forwarding is compiled out.
REQ-009 The FSM SHALL have states RST, RUN, FLUSH, INT and PRED, with a down-counter cnt of 3 bits.
REQ-010 The priority of events in RUN SHALL be, highest first: irq&&irq_en, redirect_req, raw_stall, predict_taken.
REQ-011 When irq&&irq_en occurs in RUN, the block SHALL:
- assert dec_int=1 and dec_nop=1 in that cycle;
- go to INT with cnt=INT_CYC-1;
- drive pc_load=1 and pc_mux_sel=3'd2 in the first INT cycle.
REQ-012 irq SHALL be ignored outside RUN; it is not latched.
REQ-013 When redirect_req occurs in RUN, the block SHALL drive pc_load=1, pc_mux_sel=redirect_src and dec_nop=1 in the same cycle, then go to FLUSH with cnt=FLUSH_CYC-1.
REQ-014 During a raw_stall in RUN, the block SHALL drive pc_stall=1, fetch_stall=1, dec_nop=1 and pc_load=0, stay in RUN, and ignore predict_taken.
REQ-015 When predict_taken is accepted in RUN, the block SHALL drive pc_load=1, pc_mux_sel=3'd4 and fetch_stall=1, then go to PRED for one cycle with dec_nop=1; predict_taken SHALL be ignored while in PRED.
REQ-016 In FLUSH, INT and RST the block SHALL drive dec_nop=1; it SHALL return to RUN when cnt==0, otherwise decrement cnt.
REQ-017 A redirect_req arriving in FLUSH or PRED SHALL reload the redirect, restart FLUSH with cnt=FLUSH_CYC-1, and assert pc_load.
REQ-018 pc_inc SHALL equal !reset && !pc_load && !pc_stall.
REQ-019 When no load, stall or redirect is active, pc_mux_sel SHALL be 3'd0.
REQ-020 stall_cycles SHALL increment on each raw_stall cycle, saturate at 16'hFFFF, and not wrap.

Reset
REQ-021 While reset=1, outputs SHALL be:
- pc_reset=1, dec_nop=1;
- pc_load=0, pc_inc=0, pc_stall=0, fetch_stall=0, dec_int=0;
- pc_mux_sel=0, fwd selects=0.
REQ-022 While reset=1, the FSM SHALL be in RST with cnt=RST_CYC-1, and stall_cycles SHALL be cleared.
REQ-023 Reset SHALL override any state or event in the same cycle; a reset mid-FLUSH or mid-INT SHALL abort it.

Configuration
REQ-024 With macro HAZARD_FWD_EN defined:
- fwd_x_sel SHALL be i+1 for the lowest-index hitting stage i, and 0 when there is no hit;
- raw_stall SHALL be asserted only for a stage-0 hit while ex_is_load=1.
REQ-025 Without HAZARD_FWD_EN, the fwd ports SHALL be absent and REQ-008 SHALL apply.

Structure
REQ-026 Package pipeline_ctrl_pkg SHALL hold the FSM state enum and the pc_mux_sel constants: PC_SEQ=0, PC_INT=2, PC_REDIR_DEF=3, PC_PRED=4.
REQ-027 Hit detection SHALL be one sub-module, hazard_match, instanced once per source operand.

Verification
REQ-028 The bench SHALL cover the following scenarios:
- reset held 3 cycles, then released: dec_nop=1 for exactly RST_CYC=2 cycles after release, then the FSM is in RUN and pc_inc=1.
- src_a=5, src_a_rd=1, dst_addr[0]=5, dst_en[0]=1 held 2 cycles with no macro: pc_stall=1 and dec_nop=1 for 2 cycles, stall_cycles=2.
- Same stimulus with HAZARD_FWD_EN and ex_is_load=0: no stall, fwd_a_sel=1.
- Same stimulus with HAZARD_FWD_EN and dst_addr[1]=5 (stage 1 hit): no stall, fwd_a_sel=2.
- redirect_req and irq&&irq_en in the same cycle: dec_int=1; pc_mux_sel=2 in the first INT cycle; dec_nop for 3 cycles; the redirect is not taken.
- predict_taken during a raw_stall: no pc_load; once the stall clears, pc_load=1 with pc_mux_sel=4, followed by one PRED nop.
